// File: rtl/ysyx_23060203_wbu_if.sv
// Handshake and result bundle of the write-back stage.
// master: the EXU/LSU side and the consumers of the commit outputs; slave: the WBU itself.
interface ysyx_23060203_wbu_if #(
  parameter int unsigned RF_ADDR_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [RF_ADDR_W-1:0] in_rd;
  logic                 in_rd_wen;
  logic                 in_is_mem;
  logic [31:0]          in_val;
  logic [31:0]          in_dnpc;

  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [31:0]          lsu_rdata;

  logic                 rf_wen;
  logic [RF_ADDR_W-1:0] rf_waddr;
  logic [31:0]          rf_wdata;

  logic                 commit_valid;
  logic [31:0]          commit_dnpc;
  logic [63:0]          instret;

  modport master (
    output in_valid, in_rd, in_rd_wen, in_is_mem, in_val, in_dnpc,
    output lsu_valid, lsu_rdata,
    input  in_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  commit_valid, commit_dnpc, instret
  );

  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_is_mem, in_val, in_dnpc,
    input  lsu_valid, lsu_rdata,
    output in_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output commit_valid, commit_dnpc, instret
  );
endinterface

// File: rtl/ysyx_23060203_wbu.sv
// Write-back stage: captures an EXU result (or waits for LSU load data), commits it to the
// register file for one cycle, signals the IFU and counts retired instructions.
module ysyx_23060203_wbu #(
  parameter int unsigned RF_ADDR_W = 5
) (
  input logic                   clock,
  input logic                   reset,
  ysyx_23060203_wbu_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StCommit} state_e;

  state_e               state_q, state_d;
  logic [RF_ADDR_W-1:0] rd_q, rd_d;
  logic                 rd_wen_q, rd_wen_d;
  logic [31:0]          result_q, result_d;
  logic [31:0]          dnpc_q, dnpc_d;
  logic [63:0]          instret_q;

  // Handshake and commit flags are flopped from the next state so every output is a register.
  logic                 in_ready_q;
  logic                 lsu_ready_q;
  logic                 commit_q;
  logic                 rf_wen_q;

  logic                 accept;

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    result_d = result_q;
    dnpc_d   = dnpc_q;
    unique case (state_q)
      StWaitMem: begin
        if (bus.lsu_valid) begin
          result_d = bus.lsu_rdata;
          state_d  = StCommit;
        end
      end
      StIdle, StCommit: begin
        state_d = StIdle;
        if (accept) begin
          rd_d     = bus.in_rd;
          rd_wen_d = bus.in_rd_wen;
          result_d = bus.in_val;
          dnpc_d   = bus.in_dnpc;
          state_d  = bus.in_is_mem ? StWaitMem : StCommit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      result_q    <= '0;
      dnpc_q      <= '0;
      instret_q   <= '0;
      in_ready_q  <= 1'b1;
      lsu_ready_q <= 1'b0;
      commit_q    <= 1'b0;
      rf_wen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      rd_wen_q    <= rd_wen_d;
      result_q    <= result_d;
      dnpc_q      <= dnpc_d;
      in_ready_q  <= (state_d != StWaitMem);
      lsu_ready_q <= (state_d == StWaitMem);
      commit_q    <= (state_d == StCommit);
      // x0 is hardwired to zero, so its writes never reach the register file.
      rf_wen_q    <= (state_d == StCommit) & rd_wen_d & (rd_d != '0);
      if (commit_q) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.lsu_ready    = lsu_ready_q;
  assign bus.rf_wen       = rf_wen_q;
  assign bus.rf_waddr     = rd_q;
  assign bus.rf_wdata     = result_q;
  assign bus.commit_valid = commit_q;
  assign bus.commit_dnpc  = dnpc_q;
  assign bus.instret      = instret_q;

endmodule

// File: doc/ysyx_23060203_wbu.md
# ysyx_23060203_wbu

Write-back stage of the ysyx_23060203 core, directly downstream of the LSU and the ALU path. It accepts one decoded/executed instruction at a time from the EXU. For memory instructions it waits for the LSU completion handshake and captures the load data. It then commits the result to the register file in a single cycle, signals completion to the IFU, and maintains the retired-instruction counter.

## Interface
Parameters:
- `RF_ADDR_W`, 5: register index width (RV32E core uses 4; upper bit is then tied 0 by the integrator).

Ports:
- `clock`  in  1  core clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  EXU result valid.
- `in_ready`  out  1  block can accept an instruction.
- `in_rd`  in  RF_ADDR_W  destination register.
- `in_rd_wen`  in  1  instruction writes `in_rd`.
- `in_is_mem`  in  1  instruction is a load/store; result comes from LSU.
- `in_val`  in  32  ALU/CSR result, used when `in_is_mem`=0.
- `in_dnpc`  in  32  next PC of this instruction.
- `lsu_valid`  in  1  LSU completion valid (LSU `out_valid`).
- `lsu_ready`  out  1  block accepts LSU completion (drives LSU `out_ready`).
- `lsu_rdata`  in  32  already-extended load data (ignored for stores).
- `rf_wen`  out  1  register-file write enable.
- `rf_waddr`  out  RF_ADDR_W  write index.
- `rf_wdata`  out  32  write data.
- `commit_valid`  out  1  one-cycle pulse: instruction retired.
- `commit_dnpc`  out  32  next PC for IFU, valid with `commit_valid`.
- `instret`  out  64  count of retired instructions.

## Operation
- States: IDLE, WAIT_MEM, COMMIT.
- `in_ready` = IDLE | COMMIT. On `in_valid & in_ready`, latch `in_rd`, `in_rd_wen`, `in_is_mem`, `in_val`, `in_dnpc`.
  - If `in_is_mem`=1, go to WAIT_MEM; otherwise go to COMMIT with result = `in_val`.
- WAIT_MEM: `lsu_ready`=1. On `lsu_valid`, latch `lsu_rdata` as result and go to COMMIT. Otherwise stay.
- COMMIT: drive the commit outputs for exactly this cycle.
  - If a new accept happens in the same cycle, go to WAIT_MEM/COMMIT per the new instruction. Otherwise go to IDLE.
- `lsu_ready`=0 outside WAIT_MEM. A `lsu_valid` in IDLE/COMMIT is not consumed; the LSU holds it.
- `rf_wen` = COMMIT & latched `rd_wen` & (latched rd ≠ 0). Writes to x0 are always suppressed.
- `rf_waddr`/`rf_wdata` = latched rd / result. They may hold stale values when `rf_wen`=0.
- `commit_valid` = COMMIT. `commit_dnpc` = latched dnpc.
- `instret` increments by 1 on every cycle in COMMIT and wraps modulo 2^64.
- Stores (`in_is_mem`=1, `in_rd_wen`=0) still wait for the LSU completion before committing.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, all latched fields 0, `instret`=0.
  - Resulting outputs during reset: `in_ready`=1, `lsu_ready`=0, `rf_wen`=0, `commit_valid`=0, `rf_waddr`=0, `rf_wdata`=0, `commit_dnpc`=0.
- Reset mid-WAIT_MEM drops the pending instruction. No commit and no `instret` change.
- Non-mem latency: accept at edge T, COMMIT during cycle T→T+1, so the RF write lands at edge T+1.
- Mem latency: LSU handshake at edge M, COMMIT during cycle M→M+1.
- Throughput: one non-mem instruction per cycle (accept in COMMIT overlaps).
- All outputs are decoded from registered state and registered fields. There is no combinational path from `in_*`/`lsu_*` inputs to `rf_*`/`commit_*`.
- `in_ready` depends only on state. It has no combinational dependency on `in_valid`.

## Test plan
- Reset then ALU op rd=5, val=0x1234_5678, dnpc=0x8000_0004 → one cycle later `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x12345678, `commit_valid`=1, `commit_dnpc`=0x80000004, `instret`=1 next cycle.
- Load rd=3, LSU `lsu_valid` after 4 cycles with 0xFFFF_FF80 → `lsu_ready` high exactly during the WAIT_MEM cycles. Commit writes x3=0xFFFFFF80 in the cycle after the handshake.
- Store (`rd_wen`=0) → `commit_valid`=1, `rf_wen`=0, `instret` increments.
- Write to rd=0 with val=0xDEADBEEF → `rf_wen`=0, `commit_valid`=1.
- Three back-to-back ALU ops with `in_valid` held high → `in_ready` continuously 1 after the first accept. Three consecutive commit cycles, `instret`=3.
- Assert `reset` low while in WAIT_MEM, then release → IDLE, `instret`=0. A later `lsu_valid` is ignored (`lsu_ready`=0) until a mem instruction is accepted.
